// File: rtl/axi_ar_xlat_front_if.sv
// rtl/axi_ar_xlat_front_if.sv - AR request, translator, memory-side AR and error record signals
interface axi_ar_xlat_front_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic [ID_W-1:0]   s_arid;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;

  logic [ADDR_W-1:0] x_vaddr;
  logic [7:0]        x_len;
  logic [2:0]        x_size;
  logic              x_start;
  logic [ADDR_W-1:0] x_paddr;
  logic              x_done;
  logic              x_drop;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [ID_W-1:0]   m_arid;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;

  logic              e_valid;
  logic              e_ready;
  logic [ID_W-1:0]   e_id;
  logic [1:0]        e_code;

  modport slave (
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize,
    input  x_paddr, x_done, x_drop, m_arready, e_ready,
    output s_arready, x_vaddr, x_len, x_size, x_start,
    output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize,
    output e_valid, e_id, e_code
  );

  modport master (
    output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize,
    output x_paddr, x_done, x_drop, m_arready, e_ready,
    input  s_arready, x_vaddr, x_len, x_size, x_start,
    input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize,
    input  e_valid, e_id, e_code
  );
endinterface

// File: rtl/axi_ar_xlat_front.sv
// rtl/axi_ar_xlat_front.sv - AR buffer plus single-outstanding translation FSM with error records
module axi_ar_xlat_front #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rstart,
  axi_ar_xlat_front_if.slave  bus,
  output logic                busy,
  output logic [15:0]         drop_cnt
);
  localparam int EW = ADDR_W + ID_W + 11;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, ERR} state_t;
  state_t state;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic [ID_W-1:0] w_id;
  logic [TW-1:0] tcnt;

  assign push = bus.s_arvalid && bus.s_arready;
  assign pop  = (state == IDLE) && (count != '0);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign busy = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.s_araddr, bus.s_arid, bus.s_arlen, bus.s_arsize};
  end

  // s_arready comes from the next occupancy, so it is a plain register with no path from pop
  always_ff @(posedge clk or posedge rstart) begin
    if (rstart) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.s_arready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count         <= count_nxt;
      bus.s_arready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rstart) begin
    if (rstart) begin
      state         <= IDLE;
      w_id          <= '0;
      tcnt          <= '0;
      drop_cnt      <= '0;
      bus.x_vaddr   <= '0;
      bus.x_len     <= '0;
      bus.x_size    <= '0;
      bus.x_start   <= 1'b0;
      bus.m_arvalid <= 1'b0;
      bus.m_araddr  <= '0;
      bus.m_arid    <= '0;
      bus.m_arlen   <= '0;
      bus.m_arsize  <= '0;
      bus.e_valid   <= 1'b0;
      bus.e_id      <= '0;
      bus.e_code    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {bus.x_vaddr, w_id, bus.x_len, bus.x_size} <= mem[rd_ptr];
            bus.x_start <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          bus.x_start <= 1'b0;
          tcnt        <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          // drop has priority over done; timeout only when neither result arrived
          if (bus.x_drop || (!bus.x_done && tcnt == TW'(TIMEOUT - 1))) begin
            bus.e_valid <= 1'b1;
            bus.e_id    <= w_id;
            bus.e_code  <= bus.x_drop ? 2'b01 : 2'b10;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            bus.x_vaddr <= '0;
            bus.x_len   <= '0;
            bus.x_size  <= '0;
            state       <= ERR;
          end else if (bus.x_done) begin
            bus.m_arvalid <= 1'b1;
            bus.m_araddr  <= bus.x_paddr;
            bus.m_arid    <= w_id;
            bus.m_arlen   <= bus.x_len;
            bus.m_arsize  <= bus.x_size;
            bus.x_vaddr   <= '0;
            bus.x_len     <= '0;
            bus.x_size    <= '0;
            state         <= ISSUE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ISSUE: begin
          if (bus.m_arready) begin
            bus.m_arvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        ERR: begin
          if (bus.e_ready) begin
            bus.e_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ar_xlat_front.sv
// tb/tb_axi_ar_xlat_front.sv - directed bench for the AR translation front end
module tb_axi_ar_xlat_front;
  logic        clk = 1'b0;
  logic        rstart;
  logic        busy;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;
  int          adj_cnt = 0;
  logic        prev_xs = 1'b0;

  axi_ar_xlat_front_if #(.ADDR_W(32), .ID_W(4)) bus ();

  axi_ar_xlat_front #(.ADDR_W(32), .ID_W(4), .FIFO_DEPTH(2), .TIMEOUT(16)) dut (
    .clk(clk), .rstart(rstart), .bus(bus), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.x_start && prev_xs) adj_cnt++;
    prev_xs = bus.x_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    logic acc;
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = addr;
    bus.s_arid    = id;
    bus.s_arlen   = len;
    bus.s_arsize  = 3'd2;
    for (int n = 0; n < 40; n++) begin
      acc = bus.s_arready;
      @(negedge clk);
      if (acc) break;
    end
    bus.s_arvalid = 1'b0;
  endtask

  task automatic wait_xstart(input string tag, output int n);
    for (n = 0; n < 30; n++) begin
      if (bus.x_start) break;
      @(negedge clk);
    end
    chk(tag, 64'(n < 30), 64'd1);
  endtask

  initial begin
    int n;
    int got;
    logic acc;
    logic [3:0] ids [4];
    logic [7:0] lens [4];

    rstart = 1'b1;
    bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_arid = 0; bus.s_arlen = 0; bus.s_arsize = 0;
    bus.x_paddr = 0; bus.x_done = 0; bus.x_drop = 0; bus.m_arready = 0; bus.e_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_s_arready", bus.s_arready, 1);
    chk("rst_m_arvalid", bus.m_arvalid, 0);
    chk("rst_e_valid", bus.e_valid, 0);
    chk("rst_x_start", bus.x_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rstart = 1'b0;
    @(negedge clk);

    // 1 single burst
    send_ar(32'h0800_0010, 4'd3, 8'd7);
    wait_xstart("t1_xstart", n);
    chk("t1_xstart_latency", n, 1);
    chk("t1_x_vaddr", bus.x_vaddr, 32'h0800_0010);
    chk("t1_x_len", bus.x_len, 7);
    @(negedge clk);
    chk("t1_x_start_pulse", bus.x_start, 0);
    @(negedge clk);
    @(negedge clk);
    bus.x_done = 1; bus.x_paddr = 32'h0800_1010;
    chk("t1_m_arvalid_early", bus.m_arvalid, 0);
    @(negedge clk);
    bus.x_done = 0;
    chk("t1_m_arvalid", bus.m_arvalid, 1);
    chk("t1_m_araddr", bus.m_araddr, 32'h0800_1010);
    chk("t1_m_arid", bus.m_arid, 3);
    chk("t1_m_arlen", bus.m_arlen, 7);
    chk("t1_m_arsize", bus.m_arsize, 2);
    chk("t1_x_vaddr_clear", bus.x_vaddr, 0);
    bus.m_arready = 1;
    @(negedge clk);
    bus.m_arready = 0;
    chk("t1_m_arvalid_done", bus.m_arvalid, 0);
    chk("t1_busy", busy, 0);

    // 2 drop
    send_ar(32'h0000_1000, 4'd5, 8'd0);
    wait_xstart("t2_xstart", n);
    @(negedge clk);
    bus.x_drop = 1;
    @(negedge clk);
    bus.x_drop = 0;
    chk("t2_e_valid", bus.e_valid, 1);
    chk("t2_e_id", bus.e_id, 5);
    chk("t2_e_code", bus.e_code, 2'b01);
    chk("t2_m_arvalid", bus.m_arvalid, 0);
    chk("t2_drop_cnt", drop_cnt, 1);
    bus.e_ready = 1;
    @(negedge clk);
    bus.e_ready = 0;
    chk("t2_e_valid_done", bus.e_valid, 0);

    // 3 timeout, late done ignored, then a normal burst
    send_ar(32'h0000_2000, 4'd6, 8'd1);
    wait_xstart("t3_xstart", n);
    repeat (16) @(negedge clk);
    chk("t3_e_valid_early", bus.e_valid, 0);
    @(negedge clk);
    chk("t3_e_valid", bus.e_valid, 1);
    chk("t3_e_code", bus.e_code, 2'b10);
    chk("t3_e_id", bus.e_id, 6);
    chk("t3_drop_cnt", drop_cnt, 2);
    bus.x_done = 1; bus.x_paddr = 32'hDEAD_0000; bus.e_ready = 1;
    @(negedge clk);
    bus.e_ready = 0;
    @(negedge clk);
    bus.x_done = 0;
    chk("t3_late_m_arvalid", bus.m_arvalid, 0);
    chk("t3_late_busy", busy, 0);
    send_ar(32'h0000_3000, 4'd7, 8'd2);
    wait_xstart("t3_next_xstart", n);
    chk("t3_next_latency", n, 1);
    @(negedge clk);
    bus.x_done = 1; bus.x_paddr = 32'h0000_9000;
    @(negedge clk);
    bus.x_done = 0;
    chk("t3_next_m_arvalid", bus.m_arvalid, 1);
    chk("t3_next_m_araddr", bus.m_araddr, 32'h0000_9000);
    chk("t3_next_m_arid", bus.m_arid, 7);
    bus.m_arready = 1;
    @(negedge clk);
    bus.m_arready = 0;

    // 4 back-to-back with m_arready low; translator answers immediately
    bus.x_done = 1; bus.x_paddr = 32'h0000_A000;
    bus.s_arvalid = 1; bus.s_arsize = 3'd2;
    for (int i = 0; i < 4; i++) begin
      bus.s_araddr = 32'h0001_0000 + 32'(i);
      bus.s_arid   = 4'(i + 1);
      bus.s_arlen  = 8'(i + 1);
      chk("t4_s_arready", bus.s_arready, (i < 3) ? 1 : 0);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    chk("t4_s_arready_full", bus.s_arready, 0);
    chk("t4_m_arvalid", bus.m_arvalid, 1);
    chk("t4_first_id", bus.m_arid, 1);
    bus.m_arready = 1;
    got = 0;
    for (int k = 0; k < 80 && got < 4; k++) begin
      acc = bus.s_arvalid && bus.s_arready;
      if (bus.m_arvalid) begin
        ids[got]  = bus.m_arid;
        lens[got] = bus.m_arlen;
        got++;
      end
      @(negedge clk);
      if (acc) bus.s_arvalid = 0;
    end
    bus.m_arready = 0; bus.x_done = 0;
    chk("t4_drained", got, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order_id", (i < got) ? ids[i] : 4'hF, 4'(i + 1));
      chk("t4_order_len", (i < got) ? lens[i] : 8'hFF, 8'(i + 1));
    end
    repeat (2) @(negedge clk);
    chk("t4_adjacent_xstart", adj_cnt, 0);
    chk("t4_busy", busy, 0);

    // 5 done and drop together
    send_ar(32'h0000_5000, 4'd9, 8'd0);
    wait_xstart("t5_xstart", n);
    @(negedge clk);
    bus.x_done = 1; bus.x_drop = 1; bus.x_paddr = 32'h0000_5500;
    @(negedge clk);
    bus.x_done = 0; bus.x_drop = 0;
    chk("t5_e_valid", bus.e_valid, 1);
    chk("t5_e_code", bus.e_code, 2'b01);
    chk("t5_e_id", bus.e_id, 9);
    chk("t5_m_arvalid", bus.m_arvalid, 0);
    chk("t5_drop_cnt", drop_cnt, 3);
    bus.e_ready = 1;
    @(negedge clk);
    bus.e_ready = 0;

    // 6 asynchronous reset while in ISSUE with a queued AR behind it
    send_ar(32'h0000_6000, 4'hA, 8'd5);
    wait_xstart("t6_xstart", n);
    @(negedge clk);
    bus.x_done = 1; bus.x_paddr = 32'h0000_7000;
    @(negedge clk);
    bus.x_done = 0;
    chk("t6_m_arvalid", bus.m_arvalid, 1);
    send_ar(32'h0000_6100, 4'hB, 8'd1);
    chk("t6_busy_before", busy, 1);
    #2 rstart = 1;
    #1;
    chk("t6_async_m_arvalid", bus.m_arvalid, 0);
    chk("t6_async_s_arready", bus.s_arready, 1);
    @(negedge clk);
    rstart = 0;
    @(negedge clk);
    chk("t6_s_arready", bus.s_arready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_x_start", bus.x_start, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    chk("t6_fifo_empty", bus.x_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
